uart_rx_mmio: RTL and testbench

Memory-mapped 8N1 UART receiver: the upstream companion to the transmit-side `uart_top` on the MIPS data bus. Samples the serial input line and frames bytes into an 8-entry receive FIFO. Exposes a data and a status register on the same `address`/`we` bus the CPU uses for data memory. Drives a level interrupt onto a spare `INT` line while the FIFO holds data.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/rx_fifo.sv | 69 ++++++
 rtl/uart_rx_mmio.sv | 159 +++++++++++++++
 tb/tb_uart_rx_mmio.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, RXSTAT layout and default MMIO base.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int unsigned STAT_NOT_EMPTY = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_OVR       = 2;
  localparam int unsigned STAT_FERR      = 3;

  // RXSTAT payload, MSB first so it packs to {ferr, ovr, full, not_empty}.
  typedef struct packed {
    logic ferr;
    logic ovr;
    logic full;
    logic not_empty;
  } rx_stat_t;

  localparam logic [31:0] UART_RX_BASE_ADDR = 32'hFFFF_0010;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous receive FIFO; power-of-two depth, registered full/empty flags.
module rx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_next;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  // A pop frees the slot a same-cycle push needs when full; an empty FIFO never pops.
  assign w_do_pop  = i_pop && !r_empty;
  assign w_do_push = i_push && (!r_full || w_do_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop) begin
      w_count_next = r_count + CW'(1);
    end else if (!w_do_push && w_do_pop) begin
      w_count_next = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver: line synchronizer, framing FSM, RX FIFO and
// RXDATA/RXSTAT register decode with a level interrupt while data is queued.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = UART_RX_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        serial_in,
  input  logic [31:0] address,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] dataIn,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int unsigned CW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned DW  = 8;
  localparam int unsigned FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]   STAT_ADDR = BASE_ADDR + 32'd4;

  logic            r_rx_meta;
  logic            r_rx_s;
  rx_state_e       r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit_idx;
  logic [DW-1:0]   r_shift;
  logic            r_ovr;
  logic            r_ferr;

  logic            w_tc;
  logic            w_push_req;
  logic            w_pop_req;
  logic            w_ferr_set;
  logic            w_ovr_set;
  logic            w_stat_wr;
  logic            w_full;
  logic            w_empty;
  logic [DW-1:0]   w_head;
  logic [FCW-1:0]  w_count;
  rx_stat_t        w_stat;
  logic            w_unused;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= serial_in;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tc = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!r_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= HALF_LOAD;
          end
        end
        ST_START: begin
          if (w_tc) begin
            r_cnt     <= BIT_LOAD;
            r_bit_idx <= '0;
            r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_DATA: begin
          if (w_tc) begin
            r_shift   <= {r_rx_s, r_shift[DW-1:1]};
            r_cnt     <= BIT_LOAD;
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_STOP: begin
          if (w_tc) begin
            r_state <= r_rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        ST_WAIT_HIGH: begin
          if (r_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_push_req = (r_state == ST_STOP) && w_tc && r_rx_s;
  assign w_ferr_set = (r_state == ST_STOP) && w_tc && !r_rx_s;
  assign w_pop_req  = re && (address == BASE_ADDR);
  assign w_stat_wr  = we && (address == STAT_ADDR);
  // A full FIFO still accepts the byte when the CPU pops on the same edge.
  assign w_ovr_set  = w_push_req && w_full && !w_pop_req;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push_req),
    .i_pop   (w_pop_req),
    .i_wdata (r_shift),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sticky error flags; a new event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovr  <= w_ovr_set  | (r_ovr  & ~(w_stat_wr & dataIn[STAT_OVR]));
      r_ferr <= w_ferr_set | (r_ferr & ~(w_stat_wr & dataIn[STAT_FERR]));
    end
  end

  assign w_stat = {r_ferr, r_ovr, w_full, ~w_empty};

  always_comb begin
    rdata = '0;
    if (address == BASE_ADDR) begin
      rdata = w_empty ? 32'h0 : {24'b0, w_head};
    end else if (address == STAT_ADDR) begin
      rdata = {28'b0, w_stat};
    end
  end

  assign irq = ~w_empty;

  assign w_unused = ^{dataIn[31:4], dataIn[1:0], w_count};

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Randomized bench for uart_rx_mmio against a queue-based model of the receive FIFO and flags.
module tb_uart_rx_mmio;

  localparam int unsigned C       = 16;
  localparam int unsigned DEPTH   = 8;
  localparam logic [31:0] RXDATA  = 32'hFFFF_0010;
  localparam logic [31:0] RXSTAT  = 32'hFFFF_0014;
  localparam int          LATENCY = 2 + C / 2 + 9 * C + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        serial_in = 1'b1;
  logic [31:0] address = 32'h0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] dataIn = 32'h0;
  logic [31:0] rdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  logic       m_ovr = 1'b0;
  logic       m_ferr = 1'b0;

  uart_rx_mmio #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (DEPTH),
    .BASE_ADDR    (RXDATA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .address   (address),
    .we        (we),
    .re        (re),
    .dataIn    (dataIn),
    .rdata     (rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void m_frame(input logic [7:0] b, input logic stop);
    if (!stop) m_ferr = 1'b1;
    else if (m_q.size() < DEPTH) m_q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [31:0] m_stat();
    return {28'b0, m_ferr, m_ovr, m_q.size() == DEPTH, m_q.size() != 0};
  endfunction

  function automatic logic [31:0] m_head();
    return (m_q.size() == 0) ? 32'h0 : {24'b0, m_q[0]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    serial_in = 1'b0;
    tick(C);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(C);
    end
    serial_in = stop;
    tick(C);
    serial_in = 1'b1;
    tick(4);
    m_frame(b, stop);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = rdata;
  endtask

  task automatic pop_rx();
    address = RXDATA;
    re = 1'b1;
    tick(1);
    re = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a;
    dataIn = d;
    we = 1'b1;
    tick(1);
    we = 1'b0;
    if (a == RXSTAT) begin
      if (d[3]) m_ferr = 1'b0;
      if (d[2]) m_ovr = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0;
    tick(3);
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    rd(RXSTAT, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_stat: got %h want 0", d); end
    rd(RXDATA, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", d); end
    rst = 1'b1;
    tick(2);
    rd(32'h0000_0000, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    int first;
    first = 0;
    fork
      send_frame(8'hA5, 1'b1);
      for (int n = 1; n <= 200; n++) begin
        @(posedge clk);
        #1;
        if (irq === 1'b1 && first == 0) first = n;
      end
    join
    n_vec++; if (first != LATENCY) begin n_err++; $display("FAIL irq_latency: got %0d want %0d", first, LATENCY); end
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL single_stat: got %h want %h", d, m_stat()); end
    rd(RXDATA, d);
    n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL single_data: got %h want %h", d, m_head()); end
    wr(RXDATA, 32'h0000_00FF);
    rd(RXDATA, d);
    n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL rxdata_write_ignored: got %h want %h", d, m_head()); end
    rd(RXDATA + 32'd8, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL beyond_stat_read: got %h want 0", d); end
    pop_rx();
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL single_stat_after_pop: got %h want %h", d, m_stat()); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL single_irq_after_pop: got %b want 0", irq); end
    pop_rx();
    rd(RXSTAT, d);
    n_vec++; if (d !== 32'h0) begin n_err++; $display("FAIL pop_while_empty: got %h want 0", d); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    for (int b = 1; b <= 9; b++) send_frame(8'(b), 1'b1);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL overrun_stat: got %h want %h", d, m_stat()); end
    for (int i = 0; i < 8; i++) begin
      rd(RXDATA, d);
      n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL overrun_pop%0d: got %h want %h", i, d, m_head()); end
      pop_rx();
    end
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL overrun_drained: got %h want %h", d, m_stat()); end
    wr(RXSTAT, 32'h4);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL ovr_clear: got %h want %h", d, m_stat()); end
  endtask

  task automatic test_ferr();
    logic [31:0] d;
    send_frame(8'h3C, 1'b0);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL ferr_stat: got %h want %h", d, m_stat()); end
    send_frame(8'h55, 1'b1);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL ferr_next_stat: got %h want %h", d, m_stat()); end
    rd(RXDATA, d);
    n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL ferr_next_data: got %h want %h", d, m_head()); end
    pop_rx();
    wr(RXSTAT, 32'h8);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL ferr_clear: got %h want %h", d, m_stat()); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic [7:0]  b;
    serial_in = 1'b0;
    tick(4);
    serial_in = 1'b1;
    tick(2 * C);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL glitch_stat: got %h want %h", d, m_stat()); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq: got %b want 0", irq); end
    b = 8'($urandom);
    send_frame(b, 1'b1);
    rd(RXDATA, d);
    n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL glitch_next_data: got %h want %h", d, m_head()); end
    pop_rx();
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    logic [7:0]  b;
    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL full_stat: got %h want %h", d, m_stat()); end
    b = 8'($urandom);
    fork
      send_frame(b, 1'b1);
      begin
        tick(LATENCY - 1);
        rd(RXDATA, d);
        n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL pushpop_head: got %h want %h", d, m_head()); end
        address = RXDATA;
        re = 1'b1;
        tick(1);
        re = 1'b0;
        void'(m_q.pop_front());
      end
    join
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL pushpop_stat: got %h want %h", d, m_stat()); end
    for (int i = 0; i < DEPTH; i++) begin
      rd(RXDATA, d);
      n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL pushpop_order%0d: got %h want %h", i, d, m_head()); end
      pop_rx();
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom), 1'b1);
      tick($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        rd(RXDATA, d);
        n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL random_pop%0d: got %h want %h", i, d, m_head()); end
        pop_rx();
      end
    end
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL random_stat: got %h want %h", d, m_stat()); end
    while (m_q.size() != 0) begin
      rd(RXDATA, d);
      n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL random_drain: got %h want %h", d, m_head()); end
      pop_rx();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    send_frame(8'($urandom), 1'b1);
    serial_in = 1'b0;
    tick(C);
    serial_in = 1'b1;
    tick(3 * C);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    m_q.delete();
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    tick(2 * C);
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL midreset_stat: got %h want %h", d, m_stat()); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b want 0", irq); end
    send_frame(8'h81, 1'b1);
    rd(RXDATA, d);
    n_vec++; if (d !== m_head()) begin n_err++; $display("FAIL midreset_next_data: got %h want %h", d, m_head()); end
    rd(RXSTAT, d);
    n_vec++; if (d !== m_stat()) begin n_err++; $display("FAIL midreset_next_stat: got %h want %h", d, m_stat()); end
    pop_rx();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_ferr();
    test_glitch();
    test_push_pop_full();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
